adder_share_arb: RTL

- Shares one external combinational W-bit adder (operands A, B; outputs out, carry) between two requesters.
- Round-robin arbitration; operands registered into the adder; result and carry registered.
- One response channel tagged with the requester ID, using a valid/ready handshake.
- Sits between the requesting datapaths and the shared adder instance.

---
 rtl/adder_share_arb.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_arb
// Purpose  : Time-shares one external combinational W-bit adder between two
//            requesters. Round-robin arbitration, registered adder operands,
//            registered sum/carry, single ID-tagged valid/ready response port.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            req{0,1}_valid/ready  - request handshake (ready is combinational)
//            req{0,1}_a/_b         - request operands
//            add_a/add_b           - operands driven to the shared adder
//            add_out/add_carry     - sum and carry returned by the adder
//            rsp_valid/ready       - response handshake
//            rsp_id/sum/carry      - response payload
//            grant_cnt0/1          - saturating 16-bit acceptance counters
//                                    (present only with ADDER_SHARE_ARB_STATS_EN)
// Options  : `define ADDER_SHARE_ARB_STATS_EN to add the grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module adder_share_arb #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic [W-1:0] add_out,
    input  logic         add_carry,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_carry
`ifdef ADDER_SHARE_ARB_STATS_EN
    ,
    output logic [15:0]  grant_cnt0,
    output logic [15:0]  grant_cnt1
`endif
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_RSP  = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic         r_last_grant;
    logic         w_accept;
    logic         w_grant_id;
    logic [W-1:0] r_add_a;
    logic [W-1:0] r_add_b;
    logic         r_rsp_valid;
    logic         r_rsp_id;
    logic [W-1:0] r_rsp_sum;
    logic         r_rsp_carry;

    // Next state and grant decision. A grant only exists in IDLE and only
    // for a requester that is currently valid; on a tie the requester that
    // did not win last time is chosen.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_grant_id  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (req0_valid && req1_valid) begin
                    w_accept   = 1'b1;
                    w_grant_id = ~r_last_grant;
                end else if (req0_valid) begin
                    w_accept   = 1'b1;
                    w_grant_id = 1'b0;
                end else if (req1_valid) begin
                    w_accept   = 1'b1;
                    w_grant_id = 1'b1;
                end
                if (w_accept) begin
                    w_state_nxt = c_CALC;
                end
            end
            c_CALC: begin
                w_state_nxt = c_RSP;
            end
            c_RSP: begin
                if (rsp_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign req0_ready = w_accept & ~w_grant_id;
    assign req1_ready = w_accept &  w_grant_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_last_grant <= 1'b1;
            r_add_a      <= '0;
            r_add_b      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_sum    <= '0;
            r_rsp_carry  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_add_a      <= w_grant_id ? req1_a : req0_a;
                r_add_b      <= w_grant_id ? req1_b : req0_b;
                r_rsp_id     <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
            // The adder has had a full cycle to settle on the registered
            // operands, so its result is captured straight from its outputs.
            if (r_state == c_CALC) begin
                r_rsp_sum   <= add_out;
                r_rsp_carry <= add_carry;
                r_rsp_valid <= 1'b1;
            end
            if ((r_state == c_RSP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_carry = r_rsp_carry;

`ifdef ADDER_SHARE_ARB_STATS_EN
    logic [15:0] r_grant_cnt0;
    logic [15:0] r_grant_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
        end else begin
            if (req0_ready && (r_grant_cnt0 != 16'hFFFF)) begin
                r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
            end
            if (req1_ready && (r_grant_cnt1 != 16'hFFFF)) begin
                r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
            end
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule
`default_nettype wire
